// File: rtl/fetch_unit.sv
// Instruction fetch unit: 2-entry {instr, pc_plus2} buffer with halt pre-decode and redirect flush.
// Optional FETCH_ALIGN_ERR_EN: a misaligned redirect sets a sticky err and parks in an ERROR state.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        err
);

`ifdef FETCH_ALIGN_ERR_EN
  typedef enum logic [1:0] {StFetch, StHalted, StError} state_e;
`else
  typedef enum logic [1:0] {StFetch, StHalted} state_e;
`endif

  state_e      state_q;
  logic [15:0] pc_q;
  logic [1:0]  count_q;
  logic        rd_q;
  logic        wr_q;
  logic [15:0] instr_q [2];
  logic [15:0] pcp2_q  [2];

  logic        transfer;
  logic        push;
  logic        pop;
  logic [15:0] pc_plus2;
  logic [15:0] target_pc;
  logic        misaligned;

  // Gating with rst_n makes the request drop as soon as reset asserts.
  assign imem_req    = rst_n && (state_q == StFetch) && (count_q < 2'd2);
  assign imem_addr   = pc_q;
  assign transfer    = imem_req && imem_ready;
  assign push        = transfer && !redirect;
  assign if_valid    = (count_q != 2'd0);
  assign pop         = if_valid && !stall;
  assign if_instr    = instr_q[rd_q];
  assign if_pc_plus2 = pcp2_q[rd_q];
  assign pc_plus2    = pc_q + 16'd2;

`ifdef FETCH_ALIGN_ERR_EN
  logic err_q;
  assign target_pc  = redirect_pc;
  assign misaligned = redirect_pc[0];
  assign err        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (redirect && misaligned) begin
      err_q <= 1'b1;
    end
  end
`else
  assign target_pc  = redirect_pc & 16'hFFFE;
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= 16'h0000;
      count_q    <= 2'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      instr_q[0] <= 16'h0000;
      instr_q[1] <= 16'h0000;
      pcp2_q[0]  <= 16'h0000;
      pcp2_q[1]  <= 16'h0000;
    end else if (redirect) begin
      count_q <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      pc_q    <= target_pc;
`ifdef FETCH_ALIGN_ERR_EN
      if (misaligned || state_q == StError) begin
        state_q <= StError;
      end else begin
        state_q <= StFetch;
      end
`else
      state_q <= StFetch;
`endif
    end else begin
      if (push) begin
        instr_q[wr_q] <= imem_data;
        pcp2_q[wr_q]  <= pc_plus2;
        wr_q          <= ~wr_q;
        pc_q          <= pc_plus2;
        // Stop fetching past a HALT; it is still delivered from the buffer.
        if (imem_data[15:11] == 5'b00000) begin
          state_q <= StHalted;
        end
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-004 The block SHALL have port imem_addr, output, 16 bits: byte address of the requested instruction.
REQ-005 The block SHALL have port imem_ready, input, 1 bit: memory response; imem_data is valid this cycle; a transfer occurs when imem_req && imem_ready.
REQ-006 The block SHALL have port imem_data, input, 16 bits: instruction word.
REQ-007 The block SHALL have port redirect, input, 1 bit: branch/jump/RTI taken; flush and refetch.
REQ-008 The block SHALL have port redirect_pc, input, 16 bits: target PC, sampled when redirect = 1.
REQ-009 The block SHALL have port stall, input, 1 bit: decode not accepting this cycle.
REQ-010 The block SHALL have port if_valid, output, 1 bit: head instruction valid; drives decoder Valid_PC.
REQ-011 The block SHALL have port if_instr, output, 16 bits: head instruction; [15:11] = opcode and [1:0] = mode to the decoder.
REQ-012 The block SHALL have port if_pc_plus2, output, 16 bits: head PC + 2, for branch/JAL/SIIC use.
REQ-013 The block SHALL have port err, output, 1 bit: sticky fetch error.

Function
REQ-014 Buffer: the block SHALL hold a 2-entry FIFO of {instr, pc_plus2}; a push occurs on a transfer and a pop occurs when if_valid && !stall.
REQ-015 if_valid SHALL equal (count != 0), and if_instr/if_pc_plus2 SHALL show the head entry, held stable while stall = 1.
REQ-016 State FETCH: imem_req SHALL be 1 exactly when state = FETCH and count < 2 (not gated by pop in the same cycle).
REQ-017 While imem_req = 1 and imem_ready = 0, imem_addr SHALL be held stable.
REQ-018 Fetch PC: on each transfer the fetch PC SHALL become PC + 2, modulo 2^16 (0xFFFE wraps to 0x0000).
REQ-019 A transfer in a cycle with no redirect SHALL be pushed with pc_plus2 = imem_addr + 2.
REQ-020 Count SHALL be unchanged on a simultaneous push and pop.
REQ-021 Halt pre-decode: a pushed word with [15:11] = 5'b00000 SHALL move the state FETCH -> HALTED, and no further requests SHALL be issued.
REQ-022 The HALT word itself SHALL still be delivered.
REQ-023 State HALTED: imem_req SHALL be 0 and the FIFO SHALL drain normally.
REQ-024 Redirect, in any state, SHALL flush the FIFO to count 0 on the next edge.
REQ-025 Redirect SHALL discard any same-cycle transfer, SHALL load the fetch PC with redirect_pc, and SHALL set state to FETCH (leaving HALTED, which covers speculatively fetched HALTs).
REQ-026 A pop in the redirect cycle SHALL still be seen by decode, since the outputs are combinational from the FIFO head.
REQ-027 After a redirect, imem_req SHALL assert with imem_addr = redirect_pc on the next cycle.
REQ-028 Stall plus redirect in the same cycle SHALL be resolved with redirect taking priority.
REQ-029 State ERROR: imem_req = 0 and the FIFO is not pushed; this state SHALL be exited only by reset.

Reset
REQ-030 While rst_n = 0 the block SHALL hold: fetch PC = 0x0000, count = 0, state = FETCH, err = 0, imem_req = 0, if_valid = 0.
REQ-031 The first request SHALL be imem_req = 1 with imem_addr = 0x0000 in the first cycle after rst_n deasserts.
REQ-032 Reset asserted mid-transfer or mid-stall SHALL abandon all state immediately; the memory SHALL see imem_req drop asynchronously.

Configuration
REQ-033 With macro FETCH_ALIGN_ERR_EN defined: redirect with redirect_pc[0] = 1 SHALL set err = 1 (sticky), flush the FIFO, and enter ERROR.
REQ-034 With FETCH_ALIGN_ERR_EN defined: a misaligned redirect coinciding with a transfer SHALL discard that data.
REQ-035 Without FETCH_ALIGN_ERR_EN: redirect_pc[0] SHALL be forced to 0, err SHALL be tied 0, and the ERROR state SHALL be absent.

Verification
REQ-036 Reset release with imem_ready held at 1 and stall = 0 -> the bench SHALL see addresses 0x0000, 0x0002, 0x0004 on consecutive cycles and if_pc_plus2 = 0x0002, 0x0004, ….
REQ-037 stall = 1 for 5 cycles with memory always ready -> the bench SHALL see exactly 2 words buffered, then imem_req = 0, and on release no word lost or duplicated.
REQ-038 Memory ready only every 3rd cycle -> imem_addr SHALL stay stable while waiting, and if_valid SHALL show gaps.
REQ-039 redirect to 0x0040 with 2 entries buffered and a transfer in the same cycle -> next cycle: count = 0 and imem_addr = 0x0040; the old words SHALL never reach if_valid.
REQ-040 HALT word (0x0000) fetched at 0x0010 -> imem_req SHALL fall after the push and the HALT SHALL be delivered; a later redirect to 0x0020 SHALL resume fetch at 0x0020.
REQ-041 Fetch PC at 0xFFFE -> the next imem_addr SHALL be 0x0000; with FETCH_ALIGN_ERR_EN defined, redirect to 0x0031 -> err = 1, imem_req = 0, persisting until rst_n = 0.
